inst_encode: RTL and testbench
==============================

# inst_encode

RV32I base-instruction encoder: the inverse of the instruction decode stage. It accepts decoded instruction fields (opcode, func3, funct7, register indices, 32-bit immediate) over a valid/ready handshake and emits the packed 32-bit instruction word with a sequential instruction-memory word address. It sits between the test/boot loader (or a microcode sequencer) and the instruction-memory write port. It flags fields that cannot be legally encoded.

## Interface
- ADDR_W, 10, width of instruction-memory word address; address counter wraps at 2^ADDR_W.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept the input this cycle.
- opcode  in  5  instruction bits [6:2].
- func3  in  3  instruction bits [14:12].
- funct7  in  7  instruction bits [31:25]; used for R-type only.
- rs1, rs2, rd  in  5 each  register indices.
- imm  in  32  full sign-extended immediate, same value the decode stage produces.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address assigned to out_inst.
- out_err  out  1  word could not be encoded; out_inst is 0.
- err_count  out  8  saturating count of errored words accepted.

## Operation
- Format from opcode: R 01100; I 00000, 00100; S 01000; B 11000; U 01101, 00101; J 11011. Any other opcode is an error.
- Common fields: bits[1:0] = 11, bits[6:2] = opcode.
- R: funct7, rs2, rs1, func3, rd. imm is ignored.
- I: imm[11:0] goes to bits [31:20], then rs1, func3, rd.
- S: imm[11:5] goes to [31:25] and imm[4:0] to [11:7], then rs2, rs1, func3.
- B: imm[12] to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to [7], then rs2, rs1, func3.
- U: imm[31:12] goes to [31:12], then rd. func3 is ignored.
- J: imm[20] to [31], imm[10:1] to [30:21], imm[11] to [20], imm[19:12] to [19:12], then rd.
- Errors; when one is detected, out_err=1 and out_inst=0:
  - unsupported opcode;
  - I/S: imm[31:11] not all equal;
  - B: imm[31:12] not all equal, or imm[0]=1;
  - J: imm[31:20] not all equal, or imm[0]=1;
  - U: imm[11:0] not 0.
- Address counter addr_q:
  - On each input accept, the word captures addr_q into out_addr and addr_q increments modulo 2^ADDR_W.
  - Errored words consume an address, so address = input index.
- err_count increments on each accepted errored input and saturates at 255.

## Timing
- Single elastic output register; latency 1 cycle from accept to out_valid.
- Input accept occurs when in_valid && in_ready.
- Output transfer occurs when out_valid && out_ready.
- in_ready = !rst && (!out_valid || out_ready). This allows full throughput of one word per cycle under continuous out_ready.
- While out_valid=1 and out_ready=0, out_inst, out_addr and out_err are held stable.
- Simultaneous output transfer and input accept: the register loads the new word and out_valid stays 1.
- Output transfer with no input accept: out_valid goes to 0 next cycle.
- Reset values (at the edge with rst=1): out_valid=0, out_inst=0, out_addr=0, out_err=0, addr_q=0, err_count=0. in_ready=0 while rst=1.
- Reset mid-operation: any pending word is discarded without transfer.
- in_valid may drop without having been accepted. Input fields are sampled only on the accept edge.

## Test plan
- Encode addi x1,x0,5: opcode 00100, func3 000, rd 1, rs1 0, imm 5 -> out_inst 0x00500093, out_addr 0, out_err 0, one cycle after accept.
- Stream back-to-back with out_ready=1:
  - sw x2,8(x1) -> 0x0020A423;
  - beq x0,x0,-4 (imm 0xFFFFFFFC) -> 0xFE000EE3;
  - jal x1,2048 -> 0x001000EF;
  - lui x5,0x12345 (imm 0x12345000) -> 0x123452B7;
  - required: out_addr 0,1,2,3 on consecutive cycles.
- Errors -> each gives out_err=1, out_inst=0, and err_count ends at 3:
  - addi with imm 2048;
  - beq with imm 3;
  - opcode 11111.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and out_inst/out_addr stay constant.
  - Then release out_ready -> the next input is accepted on the same cycle.
- ADDR_W=2: issue 5 words -> out_addr 0,1,2,3,0.
- Assert rst with out_valid=1 and out_ready=0 -> next cycle: out_valid=0, err_count=0, and the next accepted word has out_addr 0.

Source files
------------

// File: rtl/inst_encode.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word behind a
// single elastic output register, tagging each word with a sequential address.
module inst_encode #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  localparam logic [4:0] OP_R    = 5'b01100;
  localparam logic [4:0] OP_LOAD = 5'b00000;
  localparam logic [4:0] OP_IMM  = 5'b00100;
  localparam logic [4:0] OP_S    = 5'b01000;
  localparam logic [4:0] OP_B    = 5'b11000;
  localparam logic [4:0] OP_LUI  = 5'b01101;
  localparam logic [4:0] OP_AUI  = 5'b00101;
  localparam logic [4:0] OP_J    = 5'b11011;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_err_q, out_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        err_count_q, err_count_d;

  logic [31:0]       enc_inst_c;
  logic              enc_err_c;
  logic              accept_c;

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept_c = in_valid && in_ready;

  // Format selection, field packing and encodability checks.
  always_comb begin
    enc_inst_c = '0;
    enc_err_c  = 1'b0;
    case (opcode)
      OP_R: enc_inst_c = {funct7, rs2, rs1, func3, rd, opcode, 2'b11};
      OP_LOAD, OP_IMM: begin
        enc_err_c  = !((&imm[31:11]) || !(|imm[31:11]));
        enc_inst_c = {imm[11:0], rs1, func3, rd, opcode, 2'b11};
      end
      OP_S: begin
        enc_err_c  = !((&imm[31:11]) || !(|imm[31:11]));
        enc_inst_c = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode, 2'b11};
      end
      OP_B: begin
        enc_err_c  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
        enc_inst_c = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11],
                      opcode, 2'b11};
      end
      OP_LUI, OP_AUI: begin
        enc_err_c  = |imm[11:0];
        enc_inst_c = {imm[31:12], rd, opcode, 2'b11};
      end
      OP_J: begin
        enc_err_c  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
        enc_inst_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode, 2'b11};
      end
      default: enc_err_c = 1'b1;
    endcase
    if (enc_err_c) enc_inst_c = '0;
  end

  // Output register: load on accept, drain on transfer, hold under backpressure.
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    addr_d      = addr_q;
    err_count_d = err_count_q;
    if (accept_c) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_inst_c;
      out_addr_d  = addr_q;
      out_err_d   = enc_err_c;
      addr_d      = addr_q + ADDR_W'(1);
      if (enc_err_c && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= '0;
      out_err_q   <= 1'b0;
      addr_q      <= '0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      addr_q      <= addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_inst_encode.sv
// Directed bench for inst_encode: hand-encoded RV32I words, errors, backpressure,
// address wrap (second instance with ADDR_W=2) and mid-operation reset.
module tb_inst_encode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [4:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_inst;
  logic [9:0]  out_addr;
  logic [7:0]  err_count;

  logic        in_ready2, out_valid2, out_err2;
  logic [31:0] out_inst2;
  logic [1:0]  out_addr2;
  logic [7:0]  err_count2;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] OP_R   = 5'b01100;
  localparam logic [4:0] OP_IMM = 5'b00100;
  localparam logic [4:0] OP_S   = 5'b01000;
  localparam logic [4:0] OP_B   = 5'b11000;
  localparam logic [4:0] OP_LUI = 5'b01101;
  localparam logic [4:0] OP_J   = 5'b11011;
  localparam logic [4:0] OP_BAD = 5'b11111;

  always #5 clk = ~clk;

  inst_encode #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .funct7(funct7), .rs1(rs1), .rs2(rs2),
    .rd(rd), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  inst_encode #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .opcode(opcode), .func3(func3), .funct7(funct7), .rs1(rs1), .rs2(rs2),
    .rd(rd), .imm(imm), .out_valid(out_valid2), .out_ready(out_ready),
    .out_inst(out_inst2), .out_addr(out_addr2), .out_err(out_err2),
    .err_count(err_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdv,
                     input logic [31:0] im);
    opcode   = op;
    func3    = f3;
    funct7   = f7;
    rs1      = r1;
    rs2      = r2;
    rd       = rdv;
    imm      = im;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; func3 = '0; funct7 = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    #1;

    // Reset state
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // addi x1,x0,5
    out_ready = 1'b1;
    put(OP_IMM, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    step();
    in_valid = 1'b0;
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_inst", out_inst, 32'h00500093);
    check("addi_addr", 32'(out_addr), 32'd0);
    check("addi_err", 32'(out_err), 32'd0);
    step();
    check("addi_drain", 32'(out_valid), 32'd0);

    // Back-to-back stream from a fresh address counter
    do_reset();
    out_ready = 1'b1;
    put(OP_S, 3'b010, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
    step();
    check("sw_inst", out_inst, 32'h0020A423);
    check("sw_addr", 32'(out_addr), 32'd0);
    put(OP_B, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
    step();
    check("beq_inst", out_inst, 32'hFE000EE3);
    check("beq_addr", 32'(out_addr), 32'd1);
    put(OP_J, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
    step();
    check("jal_inst", out_inst, 32'h001000EF);
    check("jal_addr", 32'(out_addr), 32'd2);
    put(OP_LUI, 3'b000, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000);
    step();
    check("lui_inst", out_inst, 32'h123452B7);
    check("lui_addr", 32'(out_addr), 32'd3);
    check("lui_valid", 32'(out_valid), 32'd1);

    // Unencodable inputs
    put(OP_IMM, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
    step();
    check("err_addi_err", 32'(out_err), 32'd1);
    check("err_addi_inst", out_inst, 32'h0);
    check("err_addi_addr", 32'(out_addr), 32'd4);
    check("err_addi_cnt", 32'(err_count), 32'd1);
    put(OP_B, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
    step();
    check("err_beq_err", 32'(out_err), 32'd1);
    check("err_beq_inst", out_inst, 32'h0);
    put(OP_BAD, 3'b000, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    step();
    in_valid = 1'b0;
    check("err_op_err", 32'(out_err), 32'd1);
    check("err_op_inst", out_inst, 32'h0);
    check("err_op_addr", 32'(out_addr), 32'd6);
    check("err_count_3", 32'(err_count), 32'd3);
    step();

    // Backpressure: output held, input refused, then accepted on release
    out_ready = 1'b0;
    put(OP_IMM, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    step();
    put(OP_LUI, 3'b000, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_inst", out_inst, 32'h00500093);
      check("bp_addr", 32'(out_addr), 32'd7);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_next_inst", out_inst, 32'h123452B7);
    check("bp_next_addr", 32'(out_addr), 32'd8);
    step();

    // Address wrap on the ADDR_W=2 instance, with R-type words
    do_reset();
    out_ready = 1'b1;
    put(OP_R, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'hDEADBEEF);
    step();
    check("wrap_add_inst", out_inst2, 32'h002081B3);
    check("wrap_a0", 32'(out_addr2), 32'd0);
    put(OP_R, 3'b000, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0);
    step();
    check("wrap_sub_inst", out_inst2, 32'h402081B3);
    check("wrap_a1", 32'(out_addr2), 32'd1);
    put(OP_IMM, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    step();
    check("wrap_a2", 32'(out_addr2), 32'd2);
    put(OP_S, 3'b010, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
    step();
    check("wrap_a3", 32'(out_addr2), 32'd3);
    put(OP_J, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
    step();
    in_valid = 1'b0;
    check("wrap_a4", 32'(out_addr2), 32'd0);
    check("wrap_big_a4", 32'(out_addr), 32'd4);
    check("wrap_inst4", out_inst2, 32'h001000EF);
    check("wrap_valid2", 32'(out_valid2), 32'd1);
    check("wrap_err2", 32'(out_err2), 32'd0);
    check("wrap_cnt2", 32'(err_count2), 32'd0);
    check("wrap_ready2", 32'(in_ready2), 32'd1);
    step();

    // err_count saturation
    put(OP_LUI, 3'b000, 7'd0, 5'd0, 5'd0, 5'd5, 32'h00000001);
    step();
    check("lui_err", 32'(out_err), 32'd1);
    check("lui_err_cnt", 32'(err_count), 32'd1);
    put(OP_BAD, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < 260; i++) step();
    in_valid = 1'b0;
    check("err_sat", 32'(err_count), 32'd255);
    step();

    // Reset with a word pending under backpressure
    out_ready = 1'b0;
    put(OP_IMM, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    step();
    in_valid = 1'b0;
    check("pend_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(err_count), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    put(OP_S, 3'b010, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
    step();
    in_valid = 1'b0;
    check("mid_rst_addr", 32'(out_addr), 32'd0);
    check("mid_rst_inst", out_inst, 32'h0020A423);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
